// File: rtl/seq_canonical_form.sv
// seq_canonical_form: programmable sequential canonical-form stochastic network; define SEQ_CANONICAL_FORM_BITREV_EN for bit-reversed constant order
module seq_canonical_form #(
   parameter int NUM_CONSTS  = 2,
   parameter int NUM_VARS    = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int LEN_W       = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          cfg_we,
   input  logic [$clog2(NUM_OUTPUTS*(2**NUM_VARS))-1:0]  cfg_addr,
   input  logic [NUM_CONSTS:0]                           cfg_wdata,
   input  logic                                          start,
   input  logic [LEN_W-1:0]                              stream_len,
   input  logic [NUM_VARS-1:0]                           var_inputs,
   input  logic                                          var_valid,
   output logic                                          var_ready,
   output logic [NUM_OUTPUTS-1:0]                        outputs,
   output logic                                          out_valid,
   output logic [NUM_OUTPUTS*LEN_W-1:0]                  counts,
   output logic                                          busy,
   output logic                                          done
);
   localparam int NV = 2**NUM_VARS;
   localparam int AW = $clog2(NUM_OUTPUTS*NV);
   localparam logic [NUM_CONSTS:0] WMAX = (NUM_CONSTS+1)'(2**NUM_CONSTS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [NUM_CONSTS-1:0] sweep, c;
   logic [LEN_W-1:0] len, beats;
   logic [NUM_OUTPUTS-1:0] obits;
   logic [NUM_CONSTS:0] wclamp;
   logic accept, last, launch;
   assign var_ready = state == RUN;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign accept = var_ready & var_valid;
   assign last = beats == len - LEN_W'(1);
   assign launch = state == IDLE && start;
   assign wclamp = cfg_wdata > WMAX ? WMAX : cfg_wdata;
`ifdef SEQ_CANONICAL_FORM_BITREV_EN
   for (genvar i = 0; i < NUM_CONSTS; i++) begin : g_rev
      assign c[i] = sweep[NUM_CONSTS-1-i];
   end
`else
   assign c = sweep;
`endif
   always_comb begin
      state_nx = state == IDLE ? (start ? (stream_len == '0 ? DONE : RUN) : IDLE) :
                 state == RUN  ? (accept && last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sweep     <= '0;
         len       <= '0;
         beats     <= '0;
         outputs   <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= accept;
         if (launch) begin
            len   <= stream_len;
            beats <= '0;
            sweep <= '0;
         end
         if (accept) begin
            outputs <= obits;
            beats   <= beats + LEN_W'(1);
            sweep   <= sweep + NUM_CONSTS'(1);
         end
      end
   end
   for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
      logic [NUM_CONSTS:0] row [NV];
      logic [LEN_W-1:0] cnt;
      assign obits[k] = {1'b0, c} < row[var_inputs];
      assign counts[k*LEN_W +: LEN_W] = cnt;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt <= '0;
         else if (launch) cnt <= '0;
         else if (accept) cnt <= cnt + LEN_W'(obits[k]);
      end
      for (genvar v = 0; v < NV; v++) begin : g_w
         logic [NUM_CONSTS:0] wq;
         assign row[v] = wq;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) wq <= '0;
            else if (state == IDLE && cfg_we && cfg_addr == AW'(k*NV+v)) wq <= wclamp;
         end
      end
   end
endmodule

// File: doc/seq_canonical_form.md
# seq_canonical_form

Sequential, run-time-programmable successor to the combinational canonical-form AND-OR network for stochastic computing. The block owns its constant-input source, an internal sweep counter, so callers supply only variable bitstreams. It holds the weight matrix in writable registers instead of elaboration-time constants. Over a programmed stream length it emits one output bit per accepted input beat and accumulates per-output ones-counts, framed by a start/done handshake.

## Interface
Parameters:
- NUM_CONSTS, 2: width of internal constant word; weight resolution is 2^NUM_CONSTS levels.
- NUM_VARS, 1: number of variable bitstream inputs.
- NUM_OUTPUTS, 1: number of output bitstreams.
- LEN_W, 8: width of stream length and of each ones-counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  clog2(NUM_OUTPUTS*2^NUM_VARS)  weight index = k*2^NUM_VARS + v.
- cfg_wdata  in  NUM_CONSTS+1  weight value, 0..2^NUM_CONSTS; larger values clamp to 2^NUM_CONSTS.
- start  in  1  begin a stream; sampled only in IDLE.
- stream_len  in  LEN_W  beats in the stream, latched on accepted start.
- var_inputs  in  NUM_VARS  one bit of each variable stream.
- var_valid  in  1  var_inputs valid this cycle.
- var_ready  out  1  block accepts a beat; high only in RUN.
- outputs  out  NUM_OUTPUTS  registered output bits.
- out_valid  out  1  outputs carry a new beat.
- counts  out  NUM_OUTPUTS*LEN_W  ones-count per output; output k occupies slice [k*LEN_W +: LEN_W].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse marking end of stream.

## Operation
- Weights W[k][v] form a register file, written when cfg_we=1 and the state is IDLE. Writes in RUN or DONE are dropped.
- Per accepted beat, with c = constant word and x = var_inputs: outputs[k] = (c < W[k][x]).
  - W=0 gives 0.
  - W=2^NUM_CONSTS gives 1.
  - This matches the AND-OR canonical form.
- The constant sweep counter resets to 0 at each accepted start. It advances by 1 per accepted beat and wraps modulo 2^NUM_CONSTS.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1 with stream_len≠0. The block latches L, clears counts and the beat counter, and sets c=0.
  - IDLE→DONE on start=1 with stream_len=0. counts are cleared.
  - RUN: the beat counter increments on var_valid&var_ready. After the L-th beat is accepted, go to DONE and drop var_ready.
  - DONE→IDLE unconditionally after 1 cycle; done=1 only in DONE.
- start is ignored outside IDLE.
- counts are held from DONE until the next accepted start.
- counts cannot overflow: the maximum is L ≤ 2^LEN_W−1.
- Reset at any time, including mid-stream:
  - state=IDLE, all weights=0, counts=0, outputs=0.
  - out_valid=0, var_ready=0, busy=0, done=0, c=0.
  - The stream is aborted; no done pulse is produced.

## Timing
- var_ready is combinational from state: 1 in RUN, 0 otherwise.
- Output latency is 1 cycle. A beat accepted at edge t appears on outputs/out_valid after edge t, and counts include it at the same time.
- out_valid is 1 for exactly one cycle per accepted beat. Otherwise out_valid is 0 and outputs hold their last value.
- Last beat accepted at edge t: the FSM is in DONE after edge t, with done=1 and the final out_valid in that same cycle; IDLE follows after edge t+1.
- The earliest next start is accepted at edge t+2.
- var_valid gaps in RUN stall the sweep counter and beat counter; no beat is consumed.
- A cfg write at an edge is visible to beats accepted from the next edge onward.

## Configuration
- SEQ_CANONICAL_FORM_BITREV_EN:
  - Defined: the constant word applied is the bit-reversed sweep counter (van der Corput order, e.g. NUM_CONSTS=2 gives 0,2,1,3). This lowers output autocorrelation for short streams.
  - Undefined: the constant word equals the counter (0,1,2,3).
- In both cases any full 2^NUM_CONSTS-beat window of a constant var stream yields exactly W ones.

## Test plan
Defaults apply (NUM_CONSTS=2, NUM_VARS=1, NUM_OUTPUTS=1, LEN_W=8) unless stated.
- W[0]=1, W[1]=3; start with L=4, var=1 every cycle → counts=3, done pulse in the cycle after the 4th acceptance, busy cleared one cycle later. Output sequence 1,1,1,0 without the macro; 1,1,1,0 in the order of c=0,2,1,3 with it (c=3 gives 0).
- W[0]=1; L=8, var=0 continuous → counts=2. Without the macro, ones appear at beats 1 and 5. With the macro, ones appear where c=0, i.e. beats 1 and 5.
- Weights W[0]=4, W[1]=0; L=6, var_valid toggling 1,0,1,0… with var alternating 0,1 on valid beats → counts=3, exactly 6 out_valid pulses, and var_ready stays high through the gaps.
- start with L=0 → no var_ready, done one cycle after start, counts=0. A start issued during RUN is ignored and counts are unchanged.
- cfg_we during RUN writing W[1]=0 → write dropped and counts unaffected. The same write in IDLE takes effect on the next stream.
- rst asserted after 2 beats of an L=10 stream → all outputs and counts are 0 immediately, no done pulse, weights read back as 0 (stream with var=1 gives counts=0).
